// File: rtl/uart_port_sched.sv
// Round-robin TX scheduler and RX drain for the shared uart_new register port.
// One FSM owns the port; RX and TX polls alternate so neither side starves.
module uart_port_sched #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   tx_req,
  input  logic [8*NREQ-1:0] tx_data,
  output logic [NREQ-1:0]   tx_ack,
  output logic              rx_valid,
  output logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic [2:0]        u_a,
  output logic [31:0]       u_d,
  output logic              u_we,
  input  logic [31:0]       u_spo,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    POLL_RX  = 3'd0,
    RX_READ  = 3'd1,
    RX_CLR   = 3'd2,
    POLL_TX  = 3'd3,
    TX_WRITE = 3'd4,
    TX_GAP   = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_nx;
  logic [PW-1:0] grant;
  logic [PW-1:0] pick;
  logic [7:0]    pick_data;
  logic [7:0]    tx_hold;
  logic          found;
  logic          take_tx;
  int            j;
  logic          spo_unused;

  assign spo_unused = ^u_spo[23:0];

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_data = '0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_ptr) + k) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!found && i == j && tx_req[i]) begin
          found     = 1'b1;
          pick      = PW'(i);
          pick_data = tx_data[8*i +: 8];
        end
      end
    end
  end

  assign take_tx = (state == POLL_TX) && u_spo[24] && found;

  assign rr_nx = (grant == PW'(NREQ - 1)) ? '0
                                          : grant + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= POLL_RX;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = POLL_RX;
    case (state)
      POLL_RX:
        state_nx = (u_spo[24] && !rx_valid) ? RX_READ
                                            : POLL_TX;
      RX_READ:  state_nx = RX_CLR;
      RX_CLR:   state_nx = POLL_TX;
      POLL_TX:  state_nx = take_tx ? TX_WRITE : POLL_RX;
      TX_WRITE: state_nx = TX_GAP;
      TX_GAP:   state_nx = POLL_RX;
      default:  state_nx = POLL_RX;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      grant    <= '0;
      tx_hold  <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      if (take_tx) begin
        grant   <= pick;
        tx_hold <= pick_data;
      end
      if (state == TX_WRITE) rr_ptr <= rr_nx;
      if (state == RX_READ) begin
        rx_data  <= u_spo[31:24];
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // port drive is a pure function of state and the held grant
  always_comb begin
    u_a    = 3'd1;
    u_d    = '0;
    u_we   = 1'b0;
    tx_ack = '0;
    busy   = 1'b1;
    case (state)
      POLL_RX: busy = 1'b0;
      RX_READ: u_a  = 3'd0;
      RX_CLR:  u_we = 1'b1;
      POLL_TX: begin
        u_a  = 3'd2;
        busy = 1'b0;
      end
      TX_WRITE: begin
        u_a           = 3'd0;
        u_d           = {tx_hold, 24'h0};
        u_we          = 1'b1;
        tx_ack[grant] = 1'b1;
      end
      TX_GAP:  u_a = 3'd2;
      default: u_a = 3'd1;
    endcase
  end

endmodule

// File: tb/tb_uart_port_sched.sv
// Bench for uart_port_sched: polled UART model, byte scoreboards,
// directed scenarios followed by a randomized traffic phase.
module tb_uart_port_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  tx_req;
  logic [15:0] tx_data;
  logic [1:0]  tx_ack;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [2:0]  u_a;
  logic [31:0] u_d;
  logic        u_we;
  logic [31:0] u_spo;
  logic        busy;

  logic [2:0]  tx_req3;
  logic [23:0] tx_data3;
  logic [2:0]  tx_ack3;
  logic        rx_valid3;
  logic [7:0]  rx_data3;
  logic [2:0]  u_a3;
  logic [31:0] u_d3;
  logic        u_we3;
  logic [31:0] u_spo3;
  logic        busy3;

  always #5 clk = ~clk;

  uart_port_sched #(.NREQ(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready),
    .u_a(u_a), .u_d(u_d), .u_we(u_we), .u_spo(u_spo),
    .busy(busy)
  );

  uart_port_sched #(.NREQ(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .tx_req(tx_req3), .tx_data(tx_data3),
    .tx_ack(tx_ack3),
    .rx_valid(rx_valid3), .rx_data(rx_data3),
    .rx_ready(1'b1),
    .u_a(u_a3), .u_d(u_d3), .u_we(u_we3), .u_spo(u_spo3),
    .busy(busy3)
  );

  int checks = 0;
  int errors = 0;

  // UART model state
  int         busy_cnt = 0;
  int         busy_len = 0;
  logic       rx_new   = 1'b0;
  logic [7:0] rx_byte  = 8'h00;

  // scoreboards
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [7:0] exp_rx[$];
  logic [7:0] wlog[$];
  int         g3[$];
  int         ack3_cnt[3];

  logic        prev_idle = 1'b0;
  logic        prev_hs   = 1'b0;
  logic [1:0]  last_ack  = 2'b00;
  logic        last_rxv  = 1'b0;
  logic        last_a2   = 1'b0;
  logic [31:0] last_wd   = '0;
  int          rr_model  = 0;
  int          ack_total = 0;
  int          rx_clears = 0;
  int          ncyc      = 0;
  int          clr_cyc   = 0;
  int          wr_cyc    = 0;

  always_comb begin
    u_spo = '0;
    case (u_a)
      3'd0:    u_spo = {rx_byte, 24'h0};
      3'd1:    u_spo[24] = rx_new;
      3'd2:    u_spo[24] = (busy_cnt == 0);
      default: u_spo = '0;
    endcase
  end

  assign u_spo3   = (u_a3 == 3'd2) ? 32'h0100_0000 : '0;
  assign tx_data3 = 24'h33_22_11;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive();
    tx_req[0]     = q0.size() > 0;
    tx_req[1]     = q1.size() > 0;
    tx_data[7:0]  = (q0.size() > 0) ? q0[0] : 8'h00;
    tx_data[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
  endtask

  task automatic send(input int r, input logic [7:0] b);
    if (r == 0) begin
      q0.push_back(b);
      exp0.push_back(b);
    end else begin
      q1.push_back(b);
      exp1.push_back(b);
    end
  endtask

  task automatic inject(input logic [7:0] b);
    rx_byte = b;
    rx_new  = 1'b1;
  endtask

  // observe at negedge, apply UART/requester updates after posedge
  task automatic cycle();
    logic wr, rd, clr, hs, pop0, pop1;
    @(negedge clk);
    ncyc++;
    wr   = u_we && (u_a == 3'd0);
    rd   = !u_we && (u_a == 3'd0);
    clr  = u_we && (u_a == 3'd1);
    hs   = rx_valid && rx_ready;
    pop0 = 1'b0;
    pop1 = 1'b0;
    last_ack = tx_ack;
    last_rxv = rx_valid;
    last_a2  = (u_a == 3'd2) && !u_we;
    if (tx_ack != 2'b00) ack_total++;
    if (wr || tx_ack != 2'b00)
      chk("ack_with_write", 32'(wr && $onehot(tx_ack)), 1);
    if (wr) begin
      chk("write_after_idle", 32'(prev_idle), 1);
      chk("write_low_zero", 32'(u_d[23:0]), 0);
      wlog.push_back(u_d[31:24]);
      last_wd = u_d;
      wr_cyc  = ncyc;
      if (tx_ack[0]) begin
        chk("r0_pending", 32'(exp0.size() != 0), 1);
        if (exp0.size() != 0)
          chk("r0_byte", 32'(u_d[31:24]), 32'(exp0.pop_front()));
        pop0     = 1'b1;
        rr_model = 1;
      end
      if (tx_ack[1]) begin
        chk("r1_pending", 32'(exp1.size() != 0), 1);
        if (exp1.size() != 0)
          chk("r1_byte", 32'(u_d[31:24]), 32'(exp1.pop_front()));
        pop1     = 1'b1;
        rr_model = 0;
      end
    end
    if (rd) begin
      chk("read_needs_new", 32'(rx_new), 1);
      exp_rx.push_back(rx_byte);
    end
    if (clr) begin
      rx_clears++;
      clr_cyc = ncyc;
    end
    if (prev_hs) chk("rx_valid_drop", 32'(rx_valid), 0);
    if (hs) begin
      chk("rx_pending", 32'(exp_rx.size() != 0), 1);
      if (exp_rx.size() != 0)
        chk("rx_byte", 32'(rx_data), 32'(exp_rx.pop_front()));
    end
    prev_hs   = hs;
    prev_idle = (u_a == 3'd2) && u_spo[24];
    for (int i = 0; i < 3; i++) begin
      if (tx_ack3[i]) begin
        ack3_cnt[i]++;
        g3.push_back(i);
      end
    end
    @(posedge clk);
    #1;
    if (busy_cnt > 0) busy_cnt--;
    if (wr) busy_cnt = busy_len;
    if (clr) rx_new = 1'b0;
    if (pop0) q0.delete(0);
    if (pop1) q1.delete(0);
    drive();
  endtask

  initial begin
    int n;
    int c0;
    int w0;
    int cs;
    int first;
    logic hit;
    rst_n    = 1'b0;
    tx_req   = '0;
    tx_data  = '0;
    rx_ready = 1'b0;
    tx_req3  = '0;
    #1;
    chk("rst_tx_ack", 32'(tx_ack), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_u_we", 32'(u_we), 0);
    chk("rst_u_a", 32'(u_a), 1);
    chk("rst_u_d", u_d, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack3", 32'(tx_ack3), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single byte, idle UART
    busy_len = 3;
    send(0, 8'h41);
    drive();
    n = 0;
    do begin
      cycle();
      n++;
    end while (last_ack == 2'b00 && n < 10);
    chk("t1_ack", 32'(last_ack), 32'b01);
    chk("t1_latency", 32'(n <= 3), 1);
    chk("t1_u_d", last_wd, 32'h4100_0000);
    repeat (6) cycle();
    chk("t1_one_write", wlog.size(), 1);
    chk("t1_single_ack", ack_total, 1);

    // both requesters continuous, slow UART
    busy_len = 20;
    first    = rr_model;
    wlog.delete();
    send(0, 8'hA0);
    send(1, 8'hB1);
    send(0, 8'hA0);
    send(1, 8'hB1);
    drive();
    n = 0;
    while (wlog.size() < 4 && n < 300) begin
      cycle();
      n++;
    end
    chk("t2_writes", wlog.size(), 4);
    for (int k = 0; k < 4 && k < wlog.size(); k++)
      chk($sformatf("t2_order%0d", k), 32'(wlog[k]),
          ((first + k) % 2 == 0) ? 32'hA0 : 32'hB1);
    repeat (25) cycle();

    // RX with consumer stalled; second byte waits
    busy_len = 0;
    c0 = rx_clears;
    inject(8'h5A);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_rxv && n < 10);
    chk("t3_valid", 32'(last_rxv), 1);
    chk("t3_data", 32'(rx_data), 32'h5A);
    chk("t3_one_clear", rx_clears - c0, 1);
    inject(8'hC3);
    repeat (15) cycle();
    chk("t3_held_clears", rx_clears - c0, 1);
    chk("t3_held_data", 32'(rx_data), 32'h5A);
    chk("t3_held_new", 32'(rx_new), 1);
    rx_ready = 1'b1;
    cycle();
    rx_ready = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_rxv && n < 10);
    chk("t3_second", 32'(rx_data), 32'hC3);
    chk("t3_two_clears", rx_clears - c0, 2);
    rx_ready = 1'b1;
    cycle();
    rx_ready = 1'b0;
    repeat (3) cycle();

    // RX and TX arrive together in an RX-poll cycle
    busy_len = 2;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(last_a2 && busy_cnt == 0) && n < 20);
    cs = ncyc;
    c0 = rx_clears;
    w0 = wlog.size();
    inject(8'h33);
    send(0, 8'h7E);
    drive();
    repeat (8) cycle();
    chk("t4_rx_done", rx_clears - c0, 1);
    chk("t4_tx_done", wlog.size() - w0, 1);
    chk("t4_tx_in_8", 32'(wr_cyc - cs <= 8), 1);
    chk("t4_rx_first", 32'(clr_cyc > cs && clr_cyc < wr_cyc), 1);
    rx_ready = 1'b1;
    cycle();
    rx_ready = 1'b0;
    repeat (4) cycle();

    // reset in the middle of a TX write, with an RX byte held
    inject(8'h99);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_rxv && n < 10);
    send(0, 8'h5C);
    drive();
    hit = 1'b0;
    for (int k = 0; k < 12 && !hit; k++) begin
      @(negedge clk);
      hit = u_we && (u_a == 3'd0);
    end
    chk("t5_in_write", 32'(hit), 1);
    chk("t5_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_we_drop", 32'(u_we), 0);
    chk("t5_ack_drop", 32'(tx_ack), 0);
    chk("t5_u_a", 32'(u_a), 1);
    chk("t5_rx_valid", 32'(rx_valid), 0);
    chk("t5_busy_drop", 32'(busy), 0);
    q0.delete();
    exp0.delete();
    exp_rx.delete();
    prev_idle = 1'b0;
    prev_hs   = 1'b0;
    rr_model  = 0;
    drive();
    @(posedge clk);
    #1;
    send(0, 8'h11);
    send(1, 8'h22);
    drive();
    rst_n = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
      if (n == 1) chk("t5_rx_cleared", 32'(last_rxv), 0);
    end while (last_ack == 2'b00 && n < 12);
    chk("t5_first_grant", 32'(last_ack), 32'b01);
    repeat (30) cycle();
    chk("t5_drained", q0.size() + q1.size(), 0);

    // three requesters, 0 and 2 continuous
    tx_req3 = 3'b101;
    repeat (20) cycle();
    tx_req3 = 3'b000;
    repeat (6) cycle();
    chk("t6_grants", 32'(g3.size() >= 4), 1);
    for (int k = 0; k < 4 && k < g3.size(); k++)
      chk($sformatf("t6_grant%0d", k), g3[k],
          (k % 2 == 0) ? 0 : 2);
    chk("t6_no_ack1", ack3_cnt[1], 0);

    // randomized traffic
    repeat (400) begin
      if ($urandom_range(0, 3) == 0 && q0.size() < 4)
        send(0, 8'($urandom));
      if ($urandom_range(0, 3) == 0 && q1.size() < 4)
        send(1, 8'($urandom));
      if ($urandom_range(0, 7) == 0 && !rx_new)
        inject(8'($urandom));
      rx_ready = 1'($urandom_range(0, 1));
      busy_len = $urandom_range(0, 6);
      drive();
      cycle();
    end
    rx_ready = 1'b1;
    n = 0;
    while ((q0.size() + q1.size() + exp_rx.size() != 0
            || rx_new || rx_valid) && n < 600) begin
      cycle();
      n++;
    end
    chk("rand_tx_drained", q0.size() + q1.size(), 0);
    chk("rand_exp_drained", exp0.size() + exp1.size(), 0);
    chk("rand_rx_drained", exp_rx.size(), 0);
    chk("rand_rx_idle", 32'(rx_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
